dma_arbiter: RTL and testbench
==============================

# dma_arbiter

Two-master, single-slave arbiter for the DMA memory bus. Master 0 is the SD interface's DMA port; master 1 is a second DMA engine (USB). It grants one master at a time to the shared memory port with round-robin fairness and returns the acknowledge and read data to the granted master. A watchdog releases the bus if the memory never acknowledges.

## Interface
Parameters:
- BANK_W, 4, bank field width
- ADDR_W, 24, address field width
- ACK_TIMEOUT, 1023, cycles allowed in WAIT_ACK before forced release; 0 disables the watchdog

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_m0_request / i_m1_request  in  1  master requests a transfer
- i_m0_write / i_m1_write  in  1  1 = write, 0 = read
- i_m0_bank / i_m1_bank  in  BANK_W  target bank
- i_m0_address / i_m1_address  in  ADDR_W  word address
- i_m0_data / i_m1_data  in  32  write data
- o_m0_busy / o_m1_busy  out  1  request not accepted this cycle
- o_m0_ack / o_m1_ack  out  1  one-cycle transfer-complete pulse
- o_m0_data / o_m1_data  out  32  read data, valid with ack
- o_request  out  1  downstream request
- o_write, o_bank, o_address, o_data  out  1/BANK_W/ADDR_W/32  downstream fields
- i_busy  in  1  downstream not accepting
- i_ack  in  1  downstream completion pulse
- i_data  in  32  downstream read data, valid with i_ack
- o_timeout  out  1  sticky watchdog flag
- i_timeout_clear  in  1  clears o_timeout

## Operation
- Protocol, both sides: a requester holds request and its fields stable until it samples request && !busy; that cycle is the acceptance. Exactly one ack follows, at least 1 cycle after acceptance. There is one outstanding transfer per master and one in the arbiter.
- State IDLE:
  - All o_mX_busy = 1; o_request = 0.
  - If any request is high, latch grant (round-robin: the master not served last wins a tie) and go to ISSUE.
  - A single requester is granted regardless of the pointer.
- State ISSUE:
  - o_request and its fields mirror the granted master combinationally.
  - The granted master's busy = i_busy; the other master's busy = 1.
  - On acceptance (request && !i_busy), go to WAIT_ACK.
  - If the granted master deasserts request, go to IDLE with no transfer.
- State WAIT_ACK:
  - o_request = 0; both busy = 1.
  - On i_ack, pulse the granted master's ack the same cycle with o_mX_data = i_data. Set the last-served pointer to the granted master and go to IDLE.
- Watchdog: a counter is cleared on entry to WAIT_ACK and increments each cycle there. When it reaches ACK_TIMEOUT without i_ack:
  - Pulse ack to the granted master with data 32'h0.
  - Set o_timeout and go to IDLE.
  - A late i_ack arriving afterwards is ignored.
- i_ack in IDLE or ISSUE is ignored.
- o_timeout clears on i_timeout_clear. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values: state IDLE, pointer = master 1 (so master 0 wins the first tie), o_request 0, all busy 1, all acks 0, o_mX_data 0, o_timeout 0, counter 0.
- Reset mid-transfer aborts with no ack to either master.
- Arbitration latency: request sampled in IDLE at cycle N, grant registered, o_request high at N+1. Earliest acceptance is N+1.
- Ack latency: master ack in the same cycle as i_ack (combinational path). o_mX_data holds the last i_data between acks.
- Back-to-back: after the ack cycle the arbiter is in IDLE, so the next o_request rises 2 cycles after i_ack at the earliest.
- Continuous contention alternates grants 0,1,0,1.
- Watchdog: with ACK_TIMEOUT = T and acceptance at cycle A, the forced ack occurs at A+T. i_ack at A+T takes priority over the timeout.

## Structure
- Shared package holds the state enum (IDLE, ISSUE, WAIT_ACK) and the default widths, so they match sd_interface's DMA port widths (4-bit bank, 24-bit address, 32-bit data).
- Single module; no sub-module is needed. The master mux is a 2:1 select on the registered grant.

## Test plan
- Master 0 alone, read of bank 1 address 0x000100, memory acks 3 cycles after acceptance with 0xDEADBEEF → o_m0_ack for one cycle with o_m0_data 0xDEADBEEF; o_m1_ack never asserts.
- Both masters request writes from reset, each acked immediately → order m0, m1, m0, m1. The downstream address alternates between the two masters' values.
- i_busy held high 5 cycles in ISSUE → master busy high throughout, fields stable; acceptance on the first !i_busy cycle.
- ACK_TIMEOUT = 8, no i_ack → forced ack with data 0 at acceptance + 8, o_timeout = 1. A later i_ack is ignored; i_timeout_clear → o_timeout = 0.
- i_reset asserted in WAIT_ACK → next cycle all outputs at reset values and no ack pulse; a subsequent m0/m1 tie grants m0.
- Stray i_ack in IDLE → no master ack and no state change.

Source files
------------

// File: rtl/dma_arbiter_pkg.sv
// Shared definitions for the DMA memory-bus arbiter: FSM states and default
// field widths matching the sd_interface DMA port.
package dma_arbiter_pkg;

  localparam int DEF_BANK_W = 4;
  localparam int DEF_ADDR_W = 24;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

endpackage

// File: rtl/dma_arbiter.sv
// Two-master round-robin arbiter onto one memory port, with an ack watchdog
// that force-completes a transfer the memory never acknowledges.
module dma_arbiter
  import dma_arbiter_pkg::*;
#(
  parameter int BANK_W      = DEF_BANK_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_m0_request,
  input  logic              i_m0_write,
  input  logic [BANK_W-1:0] i_m0_bank,
  input  logic [ADDR_W-1:0] i_m0_address,
  input  logic [DATA_W-1:0] i_m0_data,
  output logic              o_m0_busy,
  output logic              o_m0_ack,
  output logic [DATA_W-1:0] o_m0_data,
  input  logic              i_m1_request,
  input  logic              i_m1_write,
  input  logic [BANK_W-1:0] i_m1_bank,
  input  logic [ADDR_W-1:0] i_m1_address,
  input  logic [DATA_W-1:0] i_m1_data,
  output logic              o_m1_busy,
  output logic              o_m1_ack,
  output logic [DATA_W-1:0] o_m1_data,
  output logic              o_request,
  output logic              o_write,
  output logic [BANK_W-1:0] o_bank,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_busy,
  input  logic              i_ack,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_timeout,
  input  logic              i_timeout_clear,
  output state_t            o_state
);

  // Handshake on both sides: the requester holds request and fields stable
  // until it sees request && !busy (acceptance); exactly one ack follows later.

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_grant;   // 0 = master 0, 1 = master 1
  logic                r_last;    // last master served
  logic [CNT_W-1:0]    r_count;
  logic [DATA_W-1:0]   r_m0_data;
  logic [DATA_W-1:0]   r_m1_data;
  logic                r_timeout;

  logic                w_gnt_req;
  logic                w_accept;
  logic                w_ack_in;
  logic                w_wd_fire;
  logic                w_done;
  logic                w_pick;
  logic [DATA_W-1:0]   w_ack_data;

  assign w_gnt_req  = r_grant ? i_m1_request : i_m0_request;
  assign w_accept   = (r_state == ISSUE) && w_gnt_req && !i_busy;
  assign w_ack_in   = (r_state == WAIT_ACK) && i_ack && !i_reset;
  // A real ack in the limit cycle wins over the watchdog.
  assign w_wd_fire  = (ACK_TIMEOUT != 0) && (r_state == WAIT_ACK) && !i_ack && !i_reset &&
                      (r_count == CNT_W'(ACK_TIMEOUT));
  assign w_done     = w_ack_in || w_wd_fire;
  assign w_ack_data = w_ack_in ? i_data : '0;
  assign w_pick     = (i_m0_request && i_m1_request) ? ~r_last : i_m1_request;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (i_m0_request || i_m1_request) w_next_state = ISSUE;
      ISSUE: begin
        if (!w_gnt_req)   w_next_state = IDLE;
        else if (!i_busy) w_next_state = WAIT_ACK;
      end
      WAIT_ACK: if (w_done) w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  always_comb begin
    o_request = (r_state == ISSUE) && w_gnt_req;
    o_write   = r_grant ? i_m1_write   : i_m0_write;
    o_bank    = r_grant ? i_m1_bank    : i_m0_bank;
    o_address = r_grant ? i_m1_address : i_m0_address;
    o_data    = r_grant ? i_m1_data    : i_m0_data;
    o_m0_busy = 1'b1;
    o_m1_busy = 1'b1;
    if (r_state == ISSUE) begin
      if (r_grant) o_m1_busy = i_busy;
      else         o_m0_busy = i_busy;
    end
    o_m0_ack  = w_done && !r_grant;
    o_m1_ack  = w_done && r_grant;
    o_m0_data = o_m0_ack ? w_ack_data : r_m0_data;
    o_m1_data = o_m1_ack ? w_ack_data : r_m1_data;
    o_timeout = r_timeout;
    o_state   = r_state;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
      r_count   <= '0;
      r_m0_data <= '0;
      r_m1_data <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == IDLE) && (i_m0_request || i_m1_request)) r_grant <= w_pick;
      // Count starts at 1 on acceptance so it equals cycles elapsed since then.
      if (w_accept)                   r_count <= CNT_W'(1);
      else if (r_state == WAIT_ACK)   r_count <= r_count + CNT_W'(1);
      if (w_done) begin
        r_last <= r_grant;
        if (r_grant) r_m1_data <= w_ack_data;
        else         r_m0_data <= w_ack_data;
      end
      if (w_wd_fire)            r_timeout <= 1'b1;
      else if (i_timeout_clear) r_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter: single read, contention order, downstream
// stall, watchdog, stray ack and reset during a pending transfer.
module tb_dma_arbiter;
  import dma_arbiter_pkg::*;

  localparam int BANK_W = 4;
  localparam int ADDR_W = 24;
  localparam int TMO    = 8;

  logic              clk = 1'b0;
  logic              i_reset = 1'b0;
  logic              m0_req = 1'b0, m1_req = 1'b0;
  logic              m0_wr = 1'b0, m1_wr = 1'b0;
  logic [BANK_W-1:0] m0_bank = '0, m1_bank = '0;
  logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
  logic [31:0]       m0_wdata = '0, m1_wdata = '0;
  logic              o_m0_busy, o_m1_busy, o_m0_ack, o_m1_ack;
  logic [31:0]       o_m0_data, o_m1_data;
  logic              o_request, o_write;
  logic [BANK_W-1:0] o_bank;
  logic [ADDR_W-1:0] o_address;
  logic [31:0]       o_data;
  logic              i_busy = 1'b0, i_ack = 1'b0;
  logic [31:0]       i_data = '0;
  logic              o_timeout;
  logic              i_timeout_clear = 1'b0;
  state_t            o_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dma_arbiter #(.BANK_W(BANK_W), .ADDR_W(ADDR_W), .ACK_TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_m0_request(m0_req), .i_m0_write(m0_wr), .i_m0_bank(m0_bank),
    .i_m0_address(m0_addr), .i_m0_data(m0_wdata),
    .o_m0_busy(o_m0_busy), .o_m0_ack(o_m0_ack), .o_m0_data(o_m0_data),
    .i_m1_request(m1_req), .i_m1_write(m1_wr), .i_m1_bank(m1_bank),
    .i_m1_address(m1_addr), .i_m1_data(m1_wdata),
    .o_m1_busy(o_m1_busy), .o_m1_ack(o_m1_ack), .o_m1_data(o_m1_data),
    .o_request(o_request), .o_write(o_write), .o_bank(o_bank),
    .o_address(o_address), .o_data(o_data),
    .i_busy(i_busy), .i_ack(i_ack), .i_data(i_data),
    .o_timeout(o_timeout), .i_timeout_clear(i_timeout_clear), .o_state(o_state)
  );

  // Each cycle begins 1 time unit after the rising edge; checks run 2 units later.
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic apply_reset;
    i_reset = 1'b1;
    next_cycle();
    next_cycle();
    i_reset = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    settle();
    n_checks++;
    if (o_state !== IDLE) begin n_errors++; $display("FAIL reset_state got %0d exp %0d", o_state, IDLE); end
    n_checks++;
    if ({o_request, o_m0_busy, o_m1_busy, o_m0_ack, o_m1_ack, o_timeout} !== 6'b011000) begin
      n_errors++;
      $display("FAIL reset_ctl got req/b0/b1/a0/a1/tmo=%b exp 011000",
               {o_request, o_m0_busy, o_m1_busy, o_m0_ack, o_m1_ack, o_timeout});
    end
    n_checks++;
    if (o_m0_data !== 32'h0 || o_m1_data !== 32'h0) begin
      n_errors++; $display("FAIL reset_data got %h/%h exp 0/0", o_m0_data, o_m1_data);
    end
  endtask

  task automatic test_single_read;
    m0_req = 1'b1; m0_wr = 1'b0; m0_bank = 4'd1; m0_addr = 24'h000100;
    settle();
    n_checks++;
    if (o_request !== 1'b0 || o_m0_busy !== 1'b1) begin
      n_errors++; $display("FAIL rd_idle got req=%b busy0=%b exp 0 1", o_request, o_m0_busy);
    end
    next_cycle(); settle();
    n_checks++;
    if (o_request !== 1'b1 || o_write !== 1'b0 || o_bank !== 4'd1 || o_address !== 24'h000100) begin
      n_errors++;
      $display("FAIL rd_issue got req=%b wr=%b bank=%h addr=%h exp 1 0 1 000100",
               o_request, o_write, o_bank, o_address);
    end
    n_checks++;
    if (o_m0_busy !== 1'b0 || o_m1_busy !== 1'b1) begin
      n_errors++; $display("FAIL rd_busy got %b%b exp 01", o_m0_busy, o_m1_busy);
    end
    next_cycle();
    m0_req = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      settle();
      n_checks++;
      if (o_m0_ack !== 1'b0 || o_m1_ack !== 1'b0 || o_request !== 1'b0) begin
        n_errors++;
        $display("FAIL rd_wait%0d got a0=%b a1=%b req=%b exp 0 0 0", k, o_m0_ack, o_m1_ack, o_request);
      end
      next_cycle();
    end
    i_ack = 1'b1; i_data = 32'hDEADBEEF;
    settle();
    n_checks++;
    if (o_m0_ack !== 1'b1 || o_m0_data !== 32'hDEADBEEF || o_m1_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL rd_ack got a0=%b d0=%h a1=%b exp 1 deadbeef 0", o_m0_ack, o_m0_data, o_m1_ack);
    end
    next_cycle();
    i_ack = 1'b0; i_data = 32'h0;
    settle();
    n_checks++;
    if (o_m0_ack !== 1'b0 || o_m0_data !== 32'hDEADBEEF || o_state !== IDLE) begin
      n_errors++;
      $display("FAIL rd_after got a0=%b d0=%h st=%0d exp 0 deadbeef %0d", o_m0_ack, o_m0_data, o_state, IDLE);
    end
  endtask

  task automatic test_contention;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_m;
    apply_reset();
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 24'h000A00; m0_wdata = 32'h0000AAAA;
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 24'h000B00; m1_wdata = 32'h0000BBBB;
    for (int i = 0; i < 4; i++) begin
      exp_m    = i[0];
      exp_addr = exp_m ? 24'h000B00 : 24'h000A00;
      next_cycle(); settle();
      n_checks++;
      if (o_request !== 1'b1 || o_write !== 1'b1 || o_address !== exp_addr) begin
        n_errors++;
        $display("FAIL cont_issue%0d got req=%b wr=%b addr=%h exp 1 1 %h", i, o_request, o_write, o_address, exp_addr);
      end
      next_cycle();
      i_ack = 1'b1; i_data = 32'h100 + i;
      settle();
      n_checks++;
      if (o_m0_ack !== !exp_m || o_m1_ack !== exp_m) begin
        n_errors++;
        $display("FAIL cont_ack%0d got a0=%b a1=%b exp m%0d", i, o_m0_ack, o_m1_ack, exp_m);
      end
      next_cycle();
      i_ack = 1'b0;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    m0_wr = 1'b0; m1_wr = 1'b0;
  endtask

  task automatic test_busy_stall;
    i_busy = 1'b1;
    m0_req = 1'b1; m0_wr = 1'b1; m0_bank = 4'd2; m0_addr = 24'h000123; m0_wdata = 32'h12345678;
    for (int c = 0; c < 5; c++) begin
      next_cycle(); settle();
      n_checks++;
      if (o_m0_busy !== 1'b1 || o_request !== 1'b1 || o_address !== 24'h000123 ||
          o_bank !== 4'd2 || o_data !== 32'h12345678 || o_state !== ISSUE) begin
        n_errors++;
        $display("FAIL stall%0d got busy=%b req=%b addr=%h bank=%h data=%h st=%0d", c,
                 o_m0_busy, o_request, o_address, o_bank, o_data, o_state);
      end
    end
    next_cycle();
    i_busy = 1'b0;
    settle();
    n_checks++;
    if (o_m0_busy !== 1'b0 || o_request !== 1'b1) begin
      n_errors++; $display("FAIL stall_release got busy=%b req=%b exp 0 1", o_m0_busy, o_request);
    end
    next_cycle();
    m0_req = 1'b0; m0_wr = 1'b0;
    settle();
    n_checks++;
    if (o_state !== WAIT_ACK) begin n_errors++; $display("FAIL stall_accept got st=%0d exp %0d", o_state, WAIT_ACK); end
    i_ack = 1'b1; i_data = 32'h0;
    next_cycle();
    i_ack = 1'b0;
  endtask

  task automatic test_watchdog;
    m1_req = 1'b1; m1_wr = 1'b0; m1_bank = 4'd3; m1_addr = 24'h000777;
    next_cycle(); settle();
    n_checks++;
    if (o_request !== 1'b1 || o_m1_busy !== 1'b0 || o_address !== 24'h000777) begin
      n_errors++; $display("FAIL wd_issue got req=%b busy1=%b addr=%h", o_request, o_m1_busy, o_address);
    end
    for (int k = 1; k < TMO; k++) begin
      next_cycle();
      m1_req = 1'b0;
      settle();
      n_checks++;
      if (o_m1_ack !== 1'b0 || o_timeout !== 1'b0) begin
        n_errors++; $display("FAIL wd_early%0d got a1=%b tmo=%b exp 0 0", k, o_m1_ack, o_timeout);
      end
    end
    next_cycle(); settle();
    n_checks++;
    if (o_m1_ack !== 1'b1 || o_m1_data !== 32'h0 || o_m0_ack !== 1'b0) begin
      n_errors++; $display("FAIL wd_fire got a1=%b d1=%h a0=%b exp 1 0 0", o_m1_ack, o_m1_data, o_m0_ack);
    end
    next_cycle();
    i_ack = 1'b1; i_data = 32'hCAFEF00D;
    settle();
    n_checks++;
    if (o_timeout !== 1'b1 || o_state !== IDLE) begin
      n_errors++; $display("FAIL wd_flag got tmo=%b st=%0d exp 1 %0d", o_timeout, o_state, IDLE);
    end
    n_checks++;
    if (o_m1_ack !== 1'b0 || o_m0_ack !== 1'b0 || o_m1_data !== 32'h0) begin
      n_errors++; $display("FAIL wd_late got a1=%b a0=%b d1=%h exp 0 0 0", o_m1_ack, o_m0_ack, o_m1_data);
    end
    next_cycle();
    i_ack = 1'b0; i_timeout_clear = 1'b1;
    settle();
    n_checks++;
    if (o_timeout !== 1'b1) begin n_errors++; $display("FAIL wd_clear_pending got %b exp 1", o_timeout); end
    next_cycle();
    i_timeout_clear = 1'b0;
    settle();
    n_checks++;
    if (o_timeout !== 1'b0) begin n_errors++; $display("FAIL wd_cleared got %b exp 0", o_timeout); end
  endtask

  task automatic test_stray_ack;
    i_ack = 1'b1; i_data = 32'h55555555;
    settle();
    n_checks++;
    if (o_m0_ack !== 1'b0 || o_m1_ack !== 1'b0 || o_m0_data !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL stray_ack got a0=%b a1=%b d0=%h exp 0 0 deadbeef", o_m0_ack, o_m1_ack, o_m0_data);
    end
    next_cycle();
    i_ack = 1'b0;
    settle();
    n_checks++;
    if (o_state !== IDLE || o_request !== 1'b0) begin
      n_errors++; $display("FAIL stray_state got st=%0d req=%b exp %0d 0", o_state, o_request, IDLE);
    end
  endtask

  task automatic test_reset_mid;
    m1_req = 1'b1; m1_addr = 24'h000321;
    next_cycle();
    next_cycle();
    m1_req = 1'b0;
    settle();
    n_checks++;
    if (o_state !== WAIT_ACK) begin n_errors++; $display("FAIL rm_wait got st=%0d exp %0d", o_state, WAIT_ACK); end
    i_reset = 1'b1;
    next_cycle();
    i_reset = 1'b0;
    i_ack = 1'b1; i_data = 32'h77777777;
    settle();
    n_checks++;
    if (o_state !== IDLE || o_m0_ack !== 1'b0 || o_m1_ack !== 1'b0 || o_request !== 1'b0 ||
        o_m0_busy !== 1'b1 || o_m1_busy !== 1'b1 || o_m0_data !== 32'h0 || o_m1_data !== 32'h0) begin
      n_errors++;
      $display("FAIL rm_after got st=%0d a0=%b a1=%b req=%b b=%b%b d0=%h d1=%h", o_state,
               o_m0_ack, o_m1_ack, o_request, o_m0_busy, o_m1_busy, o_m0_data, o_m1_data);
    end
    next_cycle();
    i_ack = 1'b0;
    m0_req = 1'b1; m0_addr = 24'h000ABC;
    m1_req = 1'b1; m1_addr = 24'h000DEF;
    next_cycle(); settle();
    n_checks++;
    if (o_request !== 1'b1 || o_address !== 24'h000ABC || o_m0_busy !== 1'b0 || o_m1_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL rm_tie got req=%b addr=%h b0=%b b1=%b exp 1 000abc 0 1", o_request, o_address, o_m0_busy, o_m1_busy);
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  initial begin
    next_cycle();
    test_reset();
    next_cycle();
    test_single_read();
    test_contention();
    next_cycle();
    test_busy_stall();
    test_watchdog();
    next_cycle();
    test_single_read();
    next_cycle();
    test_stray_ack();
    test_reset_mid();
    next_cycle();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
